grf_wb_ctl: RTL and testbench
=============================

# grf_wb_ctl

Writeback controller that drives the single write port of the 16x32 general register file. Each cycle it merges results from the single-cycle ALU path and the variable-latency memory-load path into one byte-enabled register write. Memory results pass through a 2-entry FIFO, and a 16-bit scoreboard tracks registers with loads in flight. All register-file write-port signals come from flops, so the register file sees glitch-free address, enable and data.

## Interface
- DEPTH, 2: memory result FIFO entries; only 2 is supported.
- STARVE, 3: consecutive deferred cycles of a full FIFO head before memory takes priority.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_clk_en  in  1  global clock enable; all state is frozen when low.
- i_alu_valid  in  1  ALU result present this cycle.
- i_alu_waddr  in  4  ALU destination register.
- i_alu_wen  in  4  ALU byte-lane enables.
- i_alu_din  in  32  ALU result.
- o_alu_stall  out  1  ALU result not taken this cycle; the source must hold it.
- i_mem_valid  in  1  load result offered.
- o_mem_ready  out  1  FIFO can accept; a push occurs when i_mem_valid && o_mem_ready && i_clk_en.
- i_mem_waddr  in  4  load destination register.
- i_mem_wen  in  4  load byte-lane enables.
- i_mem_din  in  32  load data, already lane-aligned.
- i_claim_valid  in  1  a load has issued; mark its destination busy.
- i_claim_addr  in  4  register to mark busy.
- o_busy  out  16  scoreboard; bit n high means a load to register n is outstanding.
- o_waddr  out  4  register-file write address.
- o_wen  out  4  register-file byte enables.
- o_din  out  32  register-file write data.
- o_cs_b  out  1  register-file select, active low; low means a write is presented.

## Operation
- Reset values: o_cs_b=1, o_wen=0, o_waddr=0, o_din=0, o_busy=0, FIFO empty, starve counter=0, o_alu_stall=0, o_mem_ready=1.
- Arbitration is evaluated in every cycle with i_clk_en=1.
  - ALU_PRI, the default: if i_alu_valid, the ALU result issues. Otherwise the FIFO head issues if the FIFO is non-empty. Otherwise nothing issues.
  - MEM_PRI: entered when the FIFO is full and its head has been deferred by the ALU for STARVE consecutive enabled cycles. In MEM_PRI the head issues, o_alu_stall = i_alu_valid, and the ALU result is ignored. After that one issue the block returns to ALU_PRI.
  - The starve counter counts cycles in which the head was deferred while the FIFO was full. It clears on any head issue, on any cycle the FIFO is not full, and on reset.
  - o_alu_stall is combinational from the state register and i_alu_valid. It is low in ALU_PRI.
- Issue behaviour:
  - An issue loads o_waddr, o_wen and o_din from the winner and drives o_cs_b low on the next cycle, but only if the winner's wen != 0.
  - A winner with wen == 0 is consumed: o_cs_b stays 1, and for a memory entry its busy bit is still cleared.
  - With no issue, o_cs_b returns to 1 and o_wen to 0; o_waddr and o_din hold their values.
- FIFO:
  - o_mem_ready = (count < DEPTH), computed from registered count only. No push is allowed while full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle are legal; the count is then unchanged.
  - Entries issue strictly in order.
- Scoreboard:
  - A claim sets busy[i_claim_addr].
  - A memory issue clears busy[head waddr].
  - If a claim and a clear hit the same register in the same cycle, set wins.
  - ALU issues never modify o_busy.
  - Claiming an already-busy register leaves it busy.
- i_clk_en low: no push, no issue and no scoreboard change. All outputs hold, including o_cs_b.
- Reset asserted mid-operation: FIFO contents are discarded, the scoreboard clears and o_cs_b goes to 1 asynchronously.

## Timing
- ALU path: a result valid in cycle N is presented on the o_* write port in cycle N+1. The register file writes it at the end of N+1, and its bypass makes it readable in N+1.
- Memory path, minimum latency 2: push at the end of N, issue in N+1, write presented in N+2.
- The busy bit clears on the same edge that presents the write, so o_busy drops in the same cycle o_cs_b goes low.
- Throughput is one write per enabled cycle.
- A memory entry waits at most STARVE+1 cycles once the FIFO is full.

## Test plan
- ALU only: a write to R5 with wen=F and data 0x12345678 in cycle 1 -> cycle 2 shows o_cs_b=0, o_waddr=5, o_wen=F, o_din=0x12345678. Cycle 3 shows o_cs_b=1.
- Load flow: claim R3 -> o_busy=0x0008. Push R3 with wen=3 and data 0x0000ABCD -> two cycles later o_cs_b=0, o_wen=3, and o_busy=0.
- Starvation: hold i_alu_valid=1 and push two loads -> after 3 deferred cycles o_alu_stall=1 for one cycle, the head write is presented next cycle, and o_mem_ready returns high.
- Boundaries:
  - With the FIFO full, o_mem_ready=0 and a further push is refused.
  - A claim and a clear on R7 in the same cycle -> busy[7] stays 1.
  - A wen=0 entry -> consumed with o_cs_b=1.
- i_clk_en low for 3 cycles with a pending write -> outputs frozen and no FIFO movement. Re-enabling resumes in order.
- Reset asserted with 2 entries queued and o_cs_b=0 -> o_cs_b=1, o_busy=0 and o_mem_ready=1 immediately. Nothing issues after release.

Source files
------------

// File: rtl/grf_wb_ctl.sv
// Writeback controller: merges ALU and memory-load results onto the single register-file write port.
// ALU results present one cycle later, loads two cycles after push; a starved full FIFO briefly stalls the ALU.
module grf_wb_ctl #(
  parameter int DEPTH  = 2,
  parameter int STARVE = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  input  logic        i_alu_valid,
  input  logic [3:0]  i_alu_waddr,
  input  logic [3:0]  i_alu_wen,
  input  logic [31:0] i_alu_din,
  output logic        o_alu_stall,
  input  logic        i_mem_valid,
  output logic        o_mem_ready,
  input  logic [3:0]  i_mem_waddr,
  input  logic [3:0]  i_mem_wen,
  input  logic [31:0] i_mem_din,
  input  logic        i_claim_valid,
  input  logic [3:0]  i_claim_addr,
  output logic [15:0] o_busy,
  output logic [3:0]  o_waddr,
  output logic [3:0]  o_wen,
  output logic [31:0] o_din,
  output logic        o_cs_b
);

  localparam int              SW          = $clog2(STARVE + 1);
  localparam logic [1:0]      DEPTH_C     = 2'(DEPTH);
  localparam logic [SW-1:0]   STARVE_LAST = SW'(STARVE - 1);

  typedef enum logic {ALU_PRI = 1'b0, MEM_PRI = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [1:0]    count;
  logic          rd_ptr, wr_ptr;
  logic [3:0]    q_waddr [2];
  logic [3:0]    q_wen   [2];
  logic [31:0]   q_din   [2];
  logic          fifo_full, fifo_empty;
  logic          push, pop, alu_issue, deferred;
  logic [3:0]    win_waddr, win_wen;
  logic [31:0]   win_din;
  logic [15:0]   busy_nxt;

  assign fifo_full   = (count == DEPTH_C);
  assign fifo_empty  = (count == 2'd0);
  assign o_mem_ready = (count < DEPTH_C);
  assign push        = i_clk_en && i_mem_valid && o_mem_ready;
  assign deferred    = i_clk_en && (state == ALU_PRI) && i_alu_valid && fifo_full;

  always_comb begin
    alu_issue = 1'b0;
    pop       = 1'b0;
    if (i_clk_en) begin
      if (state == MEM_PRI)  pop       = !fifo_empty;
      else if (i_alu_valid)  alu_issue = 1'b1;
      else if (!fifo_empty)  pop       = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ALU_PRI;
    else       state <= state_nxt;
  end

  // FSM: next state; MEM_PRI lasts exactly one enabled cycle
  always_comb begin
    state_nxt = state;
    if (i_clk_en) begin
      case (state)
        ALU_PRI: if (deferred && starve_cnt == STARVE_LAST) state_nxt = MEM_PRI;
        MEM_PRI: state_nxt = ALU_PRI;
        default: state_nxt = ALU_PRI;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    o_alu_stall = (state == MEM_PRI) && i_alu_valid;
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (i_clk_en) begin
      if (pop || !fifo_full) starve_nxt = '0;
      else if (deferred)     starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) starve_cnt <= '0;
    else       starve_cnt <= starve_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is carried by count
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_waddr[wr_ptr] <= i_mem_waddr;
      q_wen[wr_ptr]   <= i_mem_wen;
      q_din[wr_ptr]   <= i_mem_din;
    end
  end

  always_comb begin
    win_waddr = alu_issue ? i_alu_waddr : q_waddr[rd_ptr];
    win_wen   = alu_issue ? i_alu_wen   : q_wen[rd_ptr];
    win_din   = alu_issue ? i_alu_din   : q_din[rd_ptr];
  end

  // Set after clear so a same-cycle claim keeps the register busy
  always_comb begin
    busy_nxt = o_busy;
    if (pop)                        busy_nxt[q_waddr[rd_ptr]] = 1'b0;
    if (i_clk_en && i_claim_valid)  busy_nxt[i_claim_addr]    = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_busy <= 16'h0000;
    else       o_busy <= busy_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cs_b  <= 1'b1;
      o_wen   <= 4'h0;
      o_waddr <= 4'h0;
      o_din   <= 32'h0;
    end else if (i_clk_en) begin
      if ((alu_issue || pop) && win_wen != 4'h0) begin
        o_cs_b  <= 1'b0;
        o_waddr <= win_waddr;
        o_wen   <= win_wen;
        o_din   <= win_din;
      end else begin
        o_cs_b  <= 1'b1;
        o_wen   <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_grf_wb_ctl.sv
// Directed bench for grf_wb_ctl: hand-computed expectations for ALU, load, starvation, enable and reset cases.
module tb_grf_wb_ctl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_clk_en;
  logic        i_alu_valid;
  logic [3:0]  i_alu_waddr;
  logic [3:0]  i_alu_wen;
  logic [31:0] i_alu_din;
  logic        o_alu_stall;
  logic        i_mem_valid;
  logic        o_mem_ready;
  logic [3:0]  i_mem_waddr;
  logic [3:0]  i_mem_wen;
  logic [31:0] i_mem_din;
  logic        i_claim_valid;
  logic [3:0]  i_claim_addr;
  logic [15:0] o_busy;
  logic [3:0]  o_waddr;
  logic [3:0]  o_wen;
  logic [31:0] o_din;
  logic        o_cs_b;

  int n_checks = 0;
  int n_errors = 0;

  grf_wb_ctl #(.DEPTH(2), .STARVE(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
    .i_alu_valid(i_alu_valid), .i_alu_waddr(i_alu_waddr), .i_alu_wen(i_alu_wen),
    .i_alu_din(i_alu_din), .o_alu_stall(o_alu_stall),
    .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready), .i_mem_waddr(i_mem_waddr),
    .i_mem_wen(i_mem_wen), .i_mem_din(i_mem_din),
    .i_claim_valid(i_claim_valid), .i_claim_addr(i_claim_addr), .o_busy(o_busy),
    .o_waddr(o_waddr), .o_wen(o_wen), .o_din(o_din), .o_cs_b(o_cs_b)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [3:0] a, input logic [3:0] w, input logic [31:0] d);
    i_alu_valid = v; i_alu_waddr = a; i_alu_wen = w; i_alu_din = d;
  endtask

  task automatic mem(input logic v, input logic [3:0] a, input logic [3:0] w, input logic [31:0] d);
    i_mem_valid = v; i_mem_waddr = a; i_mem_wen = w; i_mem_din = d;
  endtask

  task automatic claim(input logic v, input logic [3:0] a);
    i_claim_valid = v; i_claim_addr = a;
  endtask

  task automatic chk_wr(input string tag, input logic cs, input logic [3:0] a,
                        input logic [3:0] w, input logic [31:0] d);
    chk({tag, "_cs_b"},  32'(o_cs_b),  32'(cs));
    chk({tag, "_waddr"}, 32'(o_waddr), 32'(a));
    chk({tag, "_wen"},   32'(o_wen),   32'(w));
    chk({tag, "_din"},   o_din,        d);
  endtask

  initial begin
    i_rst = 1'b1; i_clk_en = 1'b1;
    alu(0, 0, 0, 0); mem(0, 0, 0, 0); claim(0, 0);
    repeat (2) @(posedge i_clk);
    #1;
    chk_wr("rst", 1'b1, 4'h0, 4'h0, 32'h0);
    chk("rst_busy",  32'(o_busy),      32'h0);
    chk("rst_stall", 32'(o_alu_stall), 32'h0);
    chk("rst_ready", 32'(o_mem_ready), 32'h1);
    i_rst = 1'b0;
    tick();

    // ALU only
    alu(1, 4'd5, 4'hF, 32'h12345678);
    tick();
    alu(0, 0, 0, 0);
    chk_wr("alu_n1", 1'b0, 4'd5, 4'hF, 32'h12345678);
    tick();
    chk_wr("alu_n2", 1'b1, 4'd5, 4'h0, 32'h12345678);

    // Load flow
    claim(1, 4'd3);
    tick();
    claim(0, 0);
    chk("ld_busy_set", 32'(o_busy), 32'h0008);
    mem(1, 4'd3, 4'h3, 32'h0000ABCD);
    tick();
    mem(0, 0, 0, 0);
    chk("ld_cs_wait", 32'(o_cs_b), 32'h1);
    tick();
    chk_wr("ld_wr", 1'b0, 4'd3, 4'h3, 32'h0000ABCD);
    chk("ld_busy_clr", 32'(o_busy), 32'h0000);
    tick();
    chk("ld_cs_idle", 32'(o_cs_b), 32'h1);

    // Starvation: ALU held valid, two loads fill the FIFO, a third is refused
    alu(1, 4'd9, 4'hF, 32'hAAAA0000);
    mem(1, 4'd1, 4'hF, 32'h11111111); claim(1, 4'd1);
    tick();
    mem(1, 4'd2, 4'h1, 32'h00000022); claim(1, 4'd2);
    tick();
    mem(1, 4'd4, 4'hF, 32'h44444444); claim(0, 0);
    chk("sv_full_ready", 32'(o_mem_ready), 32'h0);
    chk("sv_busy",       32'(o_busy),      32'h0006);
    chk("sv_d1_stall",   32'(o_alu_stall), 32'h0);
    tick();
    chk("sv_d2_stall",   32'(o_alu_stall), 32'h0);
    tick();
    chk("sv_d3_stall",   32'(o_alu_stall), 32'h0);
    chk("sv_d3_ready",   32'(o_mem_ready), 32'h0);
    tick();
    chk("sv_mem_stall",  32'(o_alu_stall), 32'h1);
    chk("sv_mem_ready",  32'(o_mem_ready), 32'h0);
    chk_wr("sv_alu_wr", 1'b0, 4'd9, 4'hF, 32'hAAAA0000);
    tick();
    chk_wr("sv_head_wr", 1'b0, 4'd1, 4'hF, 32'h11111111);
    chk("sv_after_stall", 32'(o_alu_stall), 32'h0);
    chk("sv_after_ready", 32'(o_mem_ready), 32'h1);
    chk("sv_busy_r1",     32'(o_busy),      32'h0004);
    mem(0, 0, 0, 0);
    tick();
    chk_wr("sv_alu_wr2", 1'b0, 4'd9, 4'hF, 32'hAAAA0000);
    alu(0, 0, 0, 0);
    tick();
    chk_wr("sv_r2_wr", 1'b0, 4'd2, 4'h1, 32'h00000022);
    chk("sv_busy_r2", 32'(o_busy), 32'h0000);
    tick();
    chk("sv_no_third", 32'(o_cs_b), 32'h1);

    // Claim and clear of R7 in the same cycle, then a wen=0 entry clears it
    claim(1, 4'd7);
    tick();
    claim(0, 0);
    mem(1, 4'd7, 4'hF, 32'h00000077);
    tick();
    mem(0, 0, 0, 0);
    claim(1, 4'd7);
    tick();
    claim(0, 0);
    chk_wr("r7_wr", 1'b0, 4'd7, 4'hF, 32'h00000077);
    chk("r7_busy_kept", 32'(o_busy), 32'h0080);
    mem(1, 4'd7, 4'h0, 32'h0000DEAD);
    tick();
    mem(0, 0, 0, 0);
    tick();
    chk_wr("wen0", 1'b1, 4'd7, 4'h0, 32'h00000077);
    chk("wen0_busy", 32'(o_busy), 32'h0000);

    // Clock enable low with a write presented and a load queued
    alu(1, 4'd10, 4'hF, 32'h0000000A);
    mem(1, 4'd6, 4'hF, 32'h00000066); claim(1, 4'd6);
    tick();
    i_clk_en = 1'b0;
    alu(1, 4'd11, 4'hF, 32'h000000BB);
    mem(1, 4'd12, 4'hF, 32'h000000CC); claim(1, 4'd12);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_wr("en_frozen", 1'b0, 4'd10, 4'hF, 32'h0000000A);
      chk("en_busy",  32'(o_busy),      32'h0040);
      chk("en_ready", 32'(o_mem_ready), 32'h1);
    end
    i_clk_en = 1'b1;
    alu(0, 0, 0, 0); mem(0, 0, 0, 0); claim(0, 0);
    tick();
    chk_wr("en_resume", 1'b0, 4'd6, 4'hF, 32'h00000066);
    chk("en_resume_busy", 32'(o_busy), 32'h0000);
    tick();
    chk("en_drained", 32'(o_cs_b), 32'h1);

    // Asynchronous reset with two entries queued and a write presented
    alu(1, 4'd13, 4'hF, 32'h0000000D);
    mem(1, 4'd14, 4'hF, 32'h0000000E); claim(1, 4'd14);
    tick();
    mem(1, 4'd15, 4'hF, 32'h0000000F); claim(0, 0);
    tick();
    alu(0, 0, 0, 0); mem(0, 0, 0, 0);
    chk("pre_rst_ready", 32'(o_mem_ready), 32'h0);
    chk("pre_rst_cs",    32'(o_cs_b),      32'h0);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_cs",    32'(o_cs_b),      32'h1);
    chk("arst_busy",  32'(o_busy),      32'h0);
    chk("arst_ready", 32'(o_mem_ready), 32'h1);
    #1 i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", 32'(o_cs_b), 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
